// File: rtl/priority_arbiter_pkg.sv
// Shared constants for the tenure-based priority arbiter.
// Port summary: none (package only) -- state encodings and mode selectors.
// Optional feature macro used by the arbiter: PRIORITY_ARBITER_RR_EN.
package priority_arbiter_pkg;

  // Arbiter states, kept as plain vectors for compatibility with older code.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  // Values of the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle between requesters and the tenure-based arbiter.
// Ports: mode, req, release_grant (requester side); grant, grant_idx, grant_valid (arbiter side).
// "release" is a reserved SystemVerilog keyword, so the end-of-tenure pulse is named release_grant.
interface priority_arbiter_rr_if #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
);

  logic             mode;
  logic [WIDTH-1:0] req;
  logic             release_grant;
  logic [WIDTH-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  // Requester side: drives requests, observes grants.
  modport master (
    output mode,
    output req,
    output release_grant,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  // Arbiter side: observes requests, drives grants.
  modport slave (
    input  mode,
    input  req,
    input  release_grant,
    output grant,
    output grant_idx,
    output grant_valid
  );

endinterface

// File: rtl/priority_arbiter_rr_select.sv
// Combinational MSB-first winner search over (req & mask).
// Ports: req, mask in; winner (one-hot), winner_idx (binary), winner_any out.
// Highest set bit wins; all outputs zero when nothing qualifies.
module arb_msb_first_select #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             winner_any
);

  always_comb begin
    winner_idx = '0;
    winner_any = 1'b0;
    winner     = '0;
    // Ascending scan: the last qualifying bit seen is the highest one.
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && mask[i]) begin
        winner_idx = IDX_W'(i);
        winner_any = 1'b1;
      end
    end
    if (winner_any) begin
      winner[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/priority_arbiter_rr.sv
// N-way arbiter with registered, tenure-based grants; fixed MSB-first or round-robin.
// Ports: clk, reset (sync, active-high), clear (sync soft reset), bus (slave modport:
//   mode/req/release_grant in, grant/grant_idx/grant_valid out). 1-cycle grant latency.
// Round-robin logic is compiled in only when PRIORITY_ARBITER_RR_EN is defined.
module priority_arbiter_rr
  import priority_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  priority_arbiter_rr_if.slave bus
);

  logic [0:0]       state_q;
  logic [WIDTH-1:0] grant_q;
  logic [IDX_W-1:0] grant_idx_q;

  logic [WIDTH-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  logic [WIDTH-1:0] full_onehot;
  logic [IDX_W-1:0] full_idx;
  logic             full_any;

  // Unmasked MSB-first search: the fixed-mode winner and the round-robin wrap case.
  arb_msb_first_select #(.WIDTH(WIDTH)) u_sel_full (
    .req        (bus.req),
    .mask       ({WIDTH{1'b1}}),
    .winner     (full_onehot),
    .winner_idx (full_idx),
    .winner_any (full_any)
  );

  // An arbitration event happens whenever no one holds the grant, or the owner releases.
  logic arb_evt;
  assign arb_evt = (state_q == ST_IDLE) || bus.release_grant;

`ifdef PRIORITY_ARBITER_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [WIDTH-1:0] rr_mask;
  logic [WIDTH-1:0] masked_onehot;
  logic [IDX_W-1:0] masked_idx;
  logic             masked_any;

  // Candidates are the requesters strictly below the last winner.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rr_mask[i] = (IDX_W'(i) < ptr_q);
    end
  end

  arb_msb_first_select #(.WIDTH(WIDTH)) u_sel_masked (
    .req        (bus.req),
    .mask       (rr_mask),
    .winner     (masked_onehot),
    .winner_idx (masked_idx),
    .winner_any (masked_any)
  );

  always_comb begin
    if (bus.mode == MODE_RR && masked_any) begin
      win_onehot = masked_onehot;
      win_idx    = masked_idx;
      win_any    = 1'b1;
    end else begin
      win_onehot = full_onehot;
      win_idx    = full_idx;
      win_any    = full_any;
    end
  end

  // The pointer follows every grant load, whichever mode picked the winner.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr_q <= '0;
    end else if (arb_evt && win_any) begin
      ptr_q <= win_idx;
    end
  end
`else
  always_comb begin
    win_onehot = full_onehot;
    win_idx    = full_idx;
    win_any    = full_any;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else if (arb_evt) begin
      if (win_any) begin
        state_q     <= ST_GRANTED;
        grant_q     <= win_onehot;
        grant_idx_q <= win_idx;
      end else begin
        state_q     <= ST_IDLE;
        grant_q     <= '0;
        grant_idx_q <= '0;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = (state_q == ST_GRANTED);

endmodule

// File: tb/tb_priority_arbiter_rr.sv
module tb_priority_arbiter_rr;

  localparam int W = 4;

`ifdef PRIORITY_ARBITER_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic clear;

  priority_arbiter_rr_if #(.WIDTH(W)) bus ();

  priority_arbiter_rr #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource and who won last.
  bit         m_granted = 1'b0;
  int         m_owner   = 0;
  int         m_last    = 0;
  logic [W-1:0] exp_grant;
  logic [1:0]   exp_idx;
  logic         exp_valid;

  // Round-robin: look below the last winner first, otherwise the top requester.
  function automatic int pick(input logic [W-1:0] r, input bit rr, input int last);
    if (rr) begin
      for (int j = last - 1; j >= 0; j--) if (r[j]) return j;
    end
    for (int j = W - 1; j >= 0; j--) if (r[j]) return j;
    return -1;
  endfunction

  // Advance the model with the inputs present this cycle, then cross one edge.
  task automatic step();
    int w;
    if (reset || clear) begin
      m_granted = 1'b0;
      m_owner   = 0;
      m_last    = 0;
    end else if (!m_granted || bus.release_grant) begin
      w = pick(bus.req, RR_BUILD && bus.mode, m_last);
      if (w >= 0) begin
        m_granted = 1'b1;
        m_owner   = w;
        m_last    = w;
      end else begin
        m_granted = 1'b0;
        m_owner   = 0;
      end
    end
    exp_valid = m_granted;
    exp_grant = m_granted ? (W'(1) << m_owner) : '0;
    exp_idx   = m_granted ? 2'(m_owner) : 2'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0;
    bus.req = 4'b1111; bus.mode = 1'b0; bus.release_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d grant=%b valid=%b want 0000/0", c, bus.grant, bus.grant_valid);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.grant !== 4'b1000 || bus.grant_idx !== 2'd3 || bus.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant grant=%b idx=%0d valid=%b want 1000/3/1", bus.grant, bus.grant_idx, bus.grant_valid);
    end
  endtask

  task automatic go_idle();
    bus.req = '0; bus.release_grant = 1'b1;
    step();
    bus.release_grant = 1'b0;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant !== 4'b0000 || bus.grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL go_idle grant=%b idx=%0d valid=%b want 0000/0/0", bus.grant, bus.grant_idx, bus.grant_valid);
    end
  endtask

  task automatic test_fixed();
    go_idle();
    bus.mode = 1'b0; bus.req = 4'b0101;
    for (int c = 0; c < 11; c++) begin
      step();
      checks++;
      if (bus.grant !== 4'b0100 || bus.grant_idx !== 2'd2 || bus.grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL fixed_hold cyc=%0d grant=%b idx=%0d want 0100/2", c, bus.grant, bus.grant_idx);
      end
    end
    bus.release_grant = 1'b1;
    step();
    bus.release_grant = 1'b0;
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_regrant grant=%b want 0100", bus.grant);
    end
    bus.release_grant = 1'b1; bus.req = 4'b0001;
    step();
    bus.release_grant = 1'b0;
    checks++;
    if (bus.grant !== 4'b0001 || bus.grant_idx !== 2'd0 || bus.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed_handover grant=%b idx=%0d want 0001/0", bus.grant, bus.grant_idx);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] rr_seq [5];
    rr_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    go_idle();
    bus.mode = 1'b1; bus.req = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (bus.grant !== exp_grant || bus.grant_valid !== 1'b1 ||
            bus.grant !== (RR_BUILD ? rr_seq[t] : 4'b1000)) begin
          errors++;
          $display("FAIL rr_tenure t=%0d c=%0d grant=%b valid=%b want %b", t, c, bus.grant, bus.grant_valid, exp_grant);
        end
        bus.release_grant = (c == 1);
        step();
      end
    end
    bus.release_grant = 1'b0;
  endtask

  task automatic test_withdrawal();
    logic [W-1:0] held;
    held = bus.grant;
    bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.grant !== held || bus.grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL withdraw_hold grant=%b valid=%b want %b/1", bus.grant, bus.grant_valid, held);
      end
    end
    go_idle();
    bus.release_grant = 1'b1;
    step();
    bus.release_grant = 1'b0;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant !== 4'b0000) begin
      errors++;
      $display("FAIL release_in_idle grant=%b valid=%b want 0000/0", bus.grant, bus.grant_valid);
    end
  endtask

  task automatic test_clear();
    bus.mode = 1'b1; bus.req = 4'b0010;
    step();
    checks++;
    if (bus.grant !== 4'b0010 || bus.grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL clear_setup grant=%b idx=%0d want 0010/1", bus.grant, bus.grant_idx);
    end
    clear = 1'b1; bus.release_grant = 1'b1; bus.req = 4'b1011;
    step();
    clear = 1'b0; bus.release_grant = 1'b0;
    checks++;
    if (bus.grant !== 4'b0000 || bus.grant_idx !== 2'd0 || bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_drop grant=%b idx=%0d valid=%b want 0000/0/0", bus.grant, bus.grant_idx, bus.grant_valid);
    end
    step();
    checks++;
    if (bus.grant !== 4'b1000 || bus.grant_idx !== 2'd3) begin
      errors++;
      $display("FAIL clear_after grant=%b idx=%0d want 1000/3", bus.grant, bus.grant_idx);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.req           = W'($urandom_range(0, 15));
      bus.mode          = 1'($urandom_range(0, 3) != 0);
      bus.release_grant = ($urandom_range(0, 2) == 0);
      clear             = ($urandom_range(0, 40) == 0);
      reset             = ($urandom_range(0, 60) == 0);
      step();
      checks++;
      if (bus.grant !== exp_grant || bus.grant_idx !== exp_idx || bus.grant_valid !== exp_valid) begin
        errors++;
        $display("FAIL random cyc=%0d grant=%b idx=%0d valid=%b want %b/%0d/%b",
                 c, bus.grant, bus.grant_idx, bus.grant_valid, exp_grant, exp_idx, exp_valid);
      end
    end
    reset = 1'b0; clear = 1'b0; bus.release_grant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_withdrawal();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
